seg7_source_sched: RTL and testbench
====================================

// Module: seg7_source_sched
// PURPOSE
//  Scheduler that shares the single 8-digit hex display between NUM_SRC CPU debug words (PC, instr, ALU, mem data).
//  Rotates sources on a dwell timer (auto) or on a step pulse (manual); a high-priority alert word preempts the display.
//  Output disp_data feeds the Seg7 driver's 32-bit data input; disp_src drives status LEDs.
// PARAMETERS
//  NUM_SRC       4           number of requesting sources (2..16)
//  IDX_W         2           width of source index, = clog2(NUM_SRC)
//  DWELL_CYCLES  50_000_000  clk cycles each source is shown in auto mode (>=2)
//  HOLD_CYCLES   25_000_000  minimum clk cycles an alert is shown (>=2)
// PORTS
//  clk           in   1              system clock; all state on posedge clk
//  rst           in   1              asynchronous, active-high reset
//  src_data      in   NUM_SRC*32     source i word at [32*i+31:32*i]
//  src_en        in   NUM_SRC        source i eligible for display
//  auto_mode     in   1              1: timer rotation, 0: manual step rotation
//  step          in   1              debounced button level; rising edge = advance
//  freeze        in   1              1: hold current word and timers
//  alert_req     in   1              alert request (level)
//  alert_data    in   32             alert word, sampled on alert entry
//  disp_data     out  32             word to display driver (registered)
//  disp_src      out  IDX_W          index of displayed source (registered)
//  disp_alert    out  1              1 while alert is displayed
//  switch_pulse  out  1              one-cycle pulse when displayed source/alert changes
// BEHAVIOUR
//  Reset: state=SHOW, cur=0, disp_data=0, disp_src=0, disp_alert=0, switch_pulse=0, dwell/hold counters=0, step_q=0.
//  States: SHOW, ALERT. SHOW->ALERT when alert_req=1 (priority over step/timer/freeze); alert_data latched that edge.
//  ALERT->SHOW when hold counter reaches HOLD_CYCLES-1 and alert_req=0; if req still 1, stay (no relatch) until it drops.
//  On return to SHOW: cur unchanged from before alert, dwell counter cleared, switch_pulse=1.
//  SHOW, freeze=0: disp_data <= src_data[cur] every cycle (1-cycle latency, live update); disp_src <= cur.
//  SHOW, freeze=1: disp_data, disp_src, dwell counter held; step edges ignored (edge detector still tracks step).
//  Advance = cur <= next enabled index after cur, searching cur+1..NUM_SRC-1 then 0..cur (wrap-around); dwell cleared.
//  Auto: advance when dwell counter = DWELL_CYCLES-1, else increment. Manual: advance on step rising edge; dwell held at 0.
//  step edge and dwell expiry in same cycle: single advance. Mode change mid-dwell: dwell cleared.
//  src_en[cur]=0 and another enabled: advance next cycle regardless of mode.
//  No source enabled: cur held, disp_data <= 32'h0000_0000, no switch_pulse.
//  Only enabled source = cur: advance selects cur again; no switch_pulse (index unchanged).
//  switch_pulse=1 for exactly one cycle, aligned with the first disp_data of the new source/alert.
//  ALERT: disp_data=latched alert_data, disp_alert=1, disp_src holds last source index.
//  rst asserted mid-operation: all outputs to reset values immediately (async); first live update 1 cycle after release.
//  Counter widths: $clog2(DWELL_CYCLES) and $clog2(HOLD_CYCLES); no overflow possible (cleared at terminal).
// STRUCTURE
//  seg7_pkg: state enum {SHOW, ALERT}, WORD_W=32 constant, default dwell/hold constants.
//  Sub-module seg7_next_src: combinational round-robin search (cur, src_en) -> next index, any_en flag.
//  Top holds FSM, dwell/hold counters, step edge detector, output registers.
// TESTING (DWELL_CYCLES=8, HOLD_CYCLES=4, NUM_SRC=4, src_data={D,C,B,A}=32'hDDDD_0003..AAAA_0000)
//  Auto, all enabled -> disp_src 0,1,2,3,0 each held 8 cycles; switch_pulse once per change.
//  Manual, src_en=4'b1010, 3 step edges -> disp_src 1,3,1,3; src_data[1] changed mid-show -> disp_data follows next cycle.
//  alert_req 1-cycle pulse, alert_data=32'hDEAD_BEEF -> disp_alert=1 for 4 cycles, then return to prior cur, pulse.
//  alert_req held 10 cycles -> alert shown 10 cycles; freeze=1 during alert ignored; alert during freeze entered.
//  src_en=0 -> disp_data=0, cur held; re-enable src 2 -> cur=2 next cycle, switch_pulse=1.
//  rst asserted mid-dwell and mid-alert -> outputs 0 same cycle; step edge + dwell expiry together -> one advance.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the seven-segment source scheduler
package seg7_pkg;
  localparam int WORD_W = 32;
  localparam int DEF_DWELL = 50_000_000;
  localparam int DEF_HOLD = 25_000_000;
  typedef enum logic {SHOW, ALERT} state_t;
endpackage

// File: rtl/seg7_next_src.sv
// seg7_next_src: round-robin search for the next enabled source after cur
module seg7_next_src #(
  parameter int NUM_SRC = 4,
  parameter int IDX_W = 2
) (
  input  logic [IDX_W-1:0]   cur,
  input  logic [NUM_SRC-1:0] src_en,
  output logic [IDX_W-1:0]   nxt,
  output logic               any_en
);
  logic [IDX_W-1:0] idx;
  // Descending scan so the nearest enabled index after cur wins; k=NUM_SRC wraps back to cur.
  always_comb begin
    nxt = cur;
    idx = cur;
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx = IDX_W'((int'(cur) + k) % NUM_SRC);
      if (src_en[idx]) nxt = idx;
    end
  end
  assign any_en = |src_en;
endmodule

// File: rtl/seg7_source_sched.sv
// seg7_source_sched: shares one 8-digit hex display between debug words, with alert preemption
module seg7_source_sched import seg7_pkg::*; #(
  parameter int NUM_SRC = 4,
  parameter int IDX_W = 2,
  parameter int DWELL_CYCLES = DEF_DWELL,
  parameter int HOLD_CYCLES = DEF_HOLD
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*WORD_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_en,
  input  logic                      auto_mode,
  input  logic                      step,
  input  logic                      freeze,
  input  logic                      alert_req,
  input  logic [WORD_W-1:0]         alert_data,
  output logic [WORD_W-1:0]         disp_data,
  output logic [IDX_W-1:0]          disp_src,
  output logic                      disp_alert,
  output logic                      switch_pulse
);
  localparam int DW = $clog2(DWELL_CYCLES);
  localparam int HW = $clog2(HOLD_CYCLES);
  state_t state, state_n;
  logic [IDX_W-1:0] cur, nxt;
  logic [DW-1:0] dwell;
  logic [HW-1:0] hold;
  logic [WORD_W-1:0] show_word;
  logic any_en, step_q, step_rise, dwell_done, hold_done, adv;
  seg7_next_src #(.NUM_SRC(NUM_SRC), .IDX_W(IDX_W)) u_next (
    .cur(cur), .src_en(src_en), .nxt(nxt), .any_en(any_en)
  );
  always_comb begin
    step_rise = step & ~step_q;
    dwell_done = dwell == DW'(DWELL_CYCLES - 1);
    hold_done = hold == HW'(HOLD_CYCLES - 1);
    show_word = any_en ? src_data[WORD_W*int'(cur) +: WORD_W] : '0;
    adv = any_en && (!src_en[cur] || step_rise || (auto_mode && dwell_done));
    state_n = (state == SHOW) ? (alert_req ? ALERT : SHOW) : ((hold_done && !alert_req) ? SHOW : ALERT);
  end
  // Alert entry/exit load the display directly so the pulse lines up with the new word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SHOW;
      cur <= '0;
      dwell <= '0;
      hold <= '0;
      step_q <= 1'b0;
      disp_data <= '0;
      disp_src <= '0;
      disp_alert <= 1'b0;
      switch_pulse <= 1'b0;
    end else begin
      state <= state_n;
      step_q <= step;
      switch_pulse <= 1'b0;
      if (state == SHOW && alert_req) begin
        disp_data <= alert_data;
        disp_alert <= 1'b1;
        switch_pulse <= 1'b1;
        hold <= '0;
      end else if (state == ALERT) begin
        if (state_n == SHOW) begin
          disp_data <= show_word;
          disp_src <= cur;
          disp_alert <= 1'b0;
          switch_pulse <= 1'b1;
          dwell <= '0;
        end else if (!hold_done) hold <= hold + 1'b1;
      end else if (!freeze) begin
        disp_data <= show_word;
        disp_src <= cur;
        switch_pulse <= cur != disp_src;
        if (adv) begin
          cur <= nxt;
          dwell <= '0;
        end else dwell <= (auto_mode && !dwell_done) ? dwell + 1'b1 : '0;
      end
    end
  end
endmodule

// File: tb/tb_seg7_source_sched.sv
// tb_seg7_source_sched: directed vector table plus multi-cycle corner sequences
module tb_seg7_source_sched;
  logic clk = 1'b0, rst = 1'b1;
  logic [127:0] src_data, words;
  logic [3:0] src_en = 4'b0000;
  logic auto_mode = 1'b0, step = 1'b0, freeze = 1'b0, alert_req = 1'b0;
  logic [31:0] alert_data = 32'hDEAD_BEEF, disp_data;
  logic [1:0] disp_src;
  logic disp_alert, switch_pulse;
  int errors = 0, checks = 0, cnt;
  typedef struct {
    logic st, fr, ar;
    logic [3:0] en;
    logic [31:0] data;
    logic [1:0] src;
    logic alrt, pls;
  } vec_t;
  vec_t vt[23];

  seg7_source_sched #(.NUM_SRC(4), .IDX_W(2), .DWELL_CYCLES(8), .HOLD_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .src_data(src_data), .src_en(src_en), .auto_mode(auto_mode),
    .step(step), .freeze(freeze), .alert_req(alert_req), .alert_data(alert_data),
    .disp_data(disp_data), .disp_src(disp_src), .disp_alert(disp_alert), .switch_pulse(switch_pulse)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] w(input int i);
    return words[32*i +: 32];
  endfunction

  initial begin
    words = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    src_data = words;
    vt[0]  = '{1'b0, 1'b0, 1'b0, 4'b1010, 32'hAAAA_0000, 2'd0, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 1'b0, 1'b0, 4'b1010, 32'hBBBB_0001, 2'd1, 1'b0, 1'b1};
    vt[2]  = '{1'b1, 1'b0, 1'b0, 4'b1010, 32'hBBBB_0001, 2'd1, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 1'b0, 4'b1010, 32'hDDDD_0003, 2'd3, 1'b0, 1'b1};
    vt[4]  = '{1'b0, 1'b0, 1'b0, 4'b1010, 32'hDDDD_0003, 2'd3, 1'b0, 1'b0};
    vt[5]  = '{1'b1, 1'b0, 1'b0, 4'b1010, 32'hDDDD_0003, 2'd3, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 1'b0, 1'b0, 4'b1010, 32'hBBBB_0001, 2'd1, 1'b0, 1'b1};
    vt[7]  = '{1'b1, 1'b0, 1'b0, 4'b1010, 32'hBBBB_0001, 2'd1, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 4'b1010, 32'hDDDD_0003, 2'd3, 1'b0, 1'b1};
    vt[9]  = '{1'b0, 1'b1, 1'b0, 4'b1010, 32'hDDDD_0003, 2'd3, 1'b0, 1'b0};
    vt[10] = '{1'b1, 1'b1, 1'b0, 4'b1010, 32'hDDDD_0003, 2'd3, 1'b0, 1'b0};
    vt[11] = '{1'b1, 1'b0, 1'b0, 4'b1010, 32'hDDDD_0003, 2'd3, 1'b0, 1'b0};
    vt[12] = '{1'b0, 1'b0, 1'b0, 4'b0000, 32'h0000_0000, 2'd3, 1'b0, 1'b0};
    vt[13] = '{1'b0, 1'b0, 1'b0, 4'b0000, 32'h0000_0000, 2'd3, 1'b0, 1'b0};
    vt[14] = '{1'b0, 1'b0, 1'b0, 4'b0100, 32'hDDDD_0003, 2'd3, 1'b0, 1'b0};
    vt[15] = '{1'b0, 1'b0, 1'b0, 4'b0100, 32'hCCCC_0002, 2'd2, 1'b0, 1'b1};
    vt[16] = '{1'b0, 1'b0, 1'b0, 4'b0100, 32'hCCCC_0002, 2'd2, 1'b0, 1'b0};
    vt[17] = '{1'b0, 1'b0, 1'b1, 4'b0100, 32'hDEAD_BEEF, 2'd2, 1'b1, 1'b1};
    vt[18] = '{1'b0, 1'b1, 1'b0, 4'b0100, 32'hDEAD_BEEF, 2'd2, 1'b1, 1'b0};
    vt[19] = '{1'b0, 1'b1, 1'b0, 4'b0100, 32'hDEAD_BEEF, 2'd2, 1'b1, 1'b0};
    vt[20] = '{1'b0, 1'b1, 1'b0, 4'b0100, 32'hDEAD_BEEF, 2'd2, 1'b1, 1'b0};
    vt[21] = '{1'b0, 1'b0, 1'b0, 4'b0100, 32'hCCCC_0002, 2'd2, 1'b0, 1'b1};
    vt[22] = '{1'b0, 1'b0, 1'b0, 4'b0100, 32'hCCCC_0002, 2'd2, 1'b0, 1'b0};

    tick();
    chk("reset data", disp_data, 32'h0);
    chk("reset src", 32'(disp_src), 32'd0);
    chk("reset alert", 32'(disp_alert), 32'd0);
    chk("reset pulse", 32'(switch_pulse), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 23; i++) begin
      step = vt[i].st;
      freeze = vt[i].fr;
      alert_req = vt[i].ar;
      src_en = vt[i].en;
      tick();
      chk($sformatf("vec%0d data", i), disp_data, vt[i].data);
      chk($sformatf("vec%0d src", i), 32'(disp_src), 32'(vt[i].src));
      chk($sformatf("vec%0d alert", i), 32'(disp_alert), 32'(vt[i].alrt));
      chk($sformatf("vec%0d pulse", i), 32'(switch_pulse), 32'(vt[i].pls));
    end
    step = 1'b0;
    freeze = 1'b0;
    alert_req = 1'b0;

    auto_mode = 1'b1;
    src_en = 4'b1111;
    do_reset();
    for (int n = 1; n <= 40; n++) begin
      tick();
      chk($sformatf("auto src e%0d", n), 32'(disp_src), ((n - 1) / 8) % 4);
      chk($sformatf("auto data e%0d", n), disp_data, w(((n - 1) / 8) % 4));
      chk($sformatf("auto pulse e%0d", n), 32'(switch_pulse), 32'(n > 1 && (n - 1) % 8 == 0));
    end

    do_reset();
    for (int n = 1; n <= 7; n++) tick();
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    chk("step+expiry src e9", 32'(disp_src), 32'd1);
    tick();
    chk("step+expiry src e10", 32'(disp_src), 32'd1);
    for (int n = 11; n <= 16; n++) tick();
    chk("step+expiry src e16", 32'(disp_src), 32'd1);
    tick();
    chk("step+expiry src e17", 32'(disp_src), 32'd2);

    do_reset();
    for (int n = 1; n <= 12; n++) tick();
    chk("pre-rst dwell src", 32'(disp_src), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("async rst dwell data", disp_data, 32'h0);
    chk("async rst dwell src", 32'(disp_src), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    chk("post-rst first data", disp_data, 32'hAAAA_0000);

    auto_mode = 1'b0;
    src_en = 4'b0001;
    tick();
    alert_req = 1'b1;
    tick();
    alert_req = 1'b0;
    chk("mid-alert entered", 32'(disp_alert), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("async rst alert", 32'(disp_alert), 32'd0);
    chk("async rst alert data", disp_data, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    chk("post-rst alert data", disp_data, 32'hAAAA_0000);

    tick();
    freeze = 1'b1;
    alert_req = 1'b1;
    cnt = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      cnt += int'(disp_alert);
    end
    chk("held alert data", disp_data, 32'hDEAD_BEEF);
    alert_req = 1'b0;
    chk("held alert cycles", cnt, 32'd10);
    tick();
    chk("held alert exit", 32'(disp_alert), 32'd0);
    chk("held alert exit pulse", 32'(switch_pulse), 32'd1);
    chk("held alert exit data", disp_data, 32'hAAAA_0000);
    freeze = 1'b0;

    src_en = 4'b0010;
    do_reset();
    tick();
    tick();
    chk("live before", disp_data, 32'hBBBB_0001);
    src_data[63:32] = 32'h1234_5678;
    tick();
    chk("live after", disp_data, 32'h1234_5678);
    chk("live no pulse", 32'(switch_pulse), 32'd0);
    src_data = words;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
